// File: rtl/lru_pkg.sv
// Shared definitions for the LRU replacement unit: request opcodes and FSM state type.
package lru_pkg;

    localparam logic [1:0] LRU_PEEK  = 2'b00;
    localparam logic [1:0] LRU_TOUCH = 2'b01;
    localparam logic [1:0] LRU_ALLOC = 2'b10;
    localparam logic [1:0] LRU_INVAL = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lru_state_t;

endpackage

// File: rtl/lru_replacer_if.sv
// Request/response bundle between a cache controller (master) and the LRU unit (slave).
interface lru_replacer_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 128
);
    localparam int WAY_BITS   = $clog2(NUM_WAYS);
    localparam int INDEX_BITS = $clog2(NUM_SETS);

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [INDEX_BITS-1:0] req_index;
    logic [WAY_BITS-1:0]   req_way;
    logic [NUM_WAYS-1:0]   req_valid_ways;
    logic                  resp_valid;
    logic [WAY_BITS-1:0]   resp_way;
    logic                  resp_was_invalid;
    logic                  init_done;

    modport master (
        output req_valid, req_op, req_index, req_way, req_valid_ways,
        input  req_ready, resp_valid, resp_way, resp_was_invalid, init_done
    );

    modport slave (
        input  req_valid, req_op, req_index, req_way, req_valid_ways,
        output req_ready, resp_valid, resp_way, resp_was_invalid, init_done
    );

endinterface

// File: rtl/lru_age_update.sv
// Combinational next-age computation for one set: promote on TOUCH/ALLOC, demote on INVAL.
module lru_age_update
    import lru_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0][WAY_BITS-1:0] age_in,
    input  logic [1:0]                        op,
    input  logic [WAY_BITS-1:0]               way,
    output logic [NUM_WAYS-1:0][WAY_BITS-1:0] age_out
);

    localparam logic [WAY_BITS-1:0] AGE_MRU = WAY_BITS'(NUM_WAYS - 1);

    logic [WAY_BITS-1:0] ref_age;
    assign ref_age = age_in[way];

    // Permutation invariant means the +/-1 below never wraps.
    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            logic [WAY_BITS-1:0] age_next;

            always_comb begin
                age_next = age_in[gi];
                case (op)
                    LRU_TOUCH, LRU_ALLOC: begin
                        if (way == WAY_BITS'(gi))
                            age_next = AGE_MRU;
                        else if (age_in[gi] > ref_age)
                            age_next = age_in[gi] - 1'b1;
                    end
                    LRU_INVAL: begin
                        if (way == WAY_BITS'(gi))
                            age_next = '0;
                        else if (age_in[gi] < ref_age)
                            age_next = age_in[gi] + 1'b1;
                    end
                    default: age_next = age_in[gi];
                endcase
            end

            assign age_out[gi] = age_next;
        end
    endgenerate

endmodule

// File: rtl/lru_replacer.sv
// True-LRU replacement unit: per-set age vectors, one request per cycle, 1-cycle response,
// invalid-way-first victim selection and a self-initialising sweep after reset.
module lru_replacer
    import lru_pkg::*;
#(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 128,
    parameter int WAY_BITS   = $clog2(NUM_WAYS),
    parameter int INDEX_BITS = $clog2(NUM_SETS)
) (
    input  logic           clk,
    input  logic           rst_n,
    lru_replacer_if.slave  bus
);

    typedef logic [NUM_WAYS-1:0][WAY_BITS-1:0] age_vec_t;

    age_vec_t age_mem [NUM_SETS];

    lru_state_t            state_reg;
    logic [INDEX_BITS-1:0] sweep_cnt_reg;
    logic                  ready_reg;
    logic                  init_done_reg;

    logic                  s2_valid_reg;
    logic [1:0]            s2_op_reg;
    logic [INDEX_BITS-1:0] s2_index_reg;
    logic [WAY_BITS-1:0]   s2_way_reg;
    logic [NUM_WAYS-1:0]   s2_mask_reg;

    age_vec_t            cur_age;
    age_vec_t            new_age;
    age_vec_t            init_vec;
    logic [WAY_BITS-1:0] lru_way;
    logic [WAY_BITS-1:0] first_invalid;
    logic                set_full;
    logic [WAY_BITS-1:0] sel_way;
    logic                was_invalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT;
            sweep_cnt_reg <= '0;
            ready_reg     <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
                    if (sweep_cnt_reg == INDEX_BITS'(NUM_SETS - 1)) begin
                        state_reg     <= ST_RUN;
                        ready_reg     <= 1'b1;
                        init_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_op_reg    <= LRU_PEEK;
            s2_index_reg <= '0;
            s2_way_reg   <= '0;
            s2_mask_reg  <= '0;
        end else begin
            s2_valid_reg <= bus.req_valid && ready_reg;
            if (bus.req_valid && ready_reg) begin
                s2_op_reg    <= bus.req_op;
                s2_index_reg <= bus.req_index;
                s2_way_reg   <= bus.req_way;
                s2_mask_reg  <= bus.req_valid_ways;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_init
            assign init_vec[gi] = WAY_BITS'(gi);
        end
    endgenerate

    assign cur_age  = age_mem[s2_index_reg];
    assign set_full = &s2_mask_reg;

    always_comb begin
        lru_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (cur_age[i] == '0)
                lru_way = WAY_BITS'(i);
        end
    end

    // Scan downward so the lowest-numbered invalid way wins.
    always_comb begin
        first_invalid = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!s2_mask_reg[i])
                first_invalid = WAY_BITS'(i);
        end
    end

    always_comb begin
        sel_way     = s2_way_reg;
        was_invalid = 1'b0;
        case (s2_op_reg)
            LRU_PEEK:  sel_way = lru_way;
            LRU_ALLOC: begin
                sel_way     = set_full ? lru_way : first_invalid;
                was_invalid = !set_full;
            end
            default:   sel_way = s2_way_reg;
        endcase
    end

    lru_age_update #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_BITS (WAY_BITS)
    ) u_age_update (
        .age_in  (cur_age),
        .op      (s2_op_reg),
        .way     (sel_way),
        .age_out (new_age)
    );

    // Write lands at the end of stage 2, so a back-to-back request to the same set reads it.
    always_ff @(posedge clk) begin
        if (state_reg == ST_INIT)
            age_mem[sweep_cnt_reg] <= init_vec;
        else if (s2_valid_reg && s2_op_reg != LRU_PEEK)
            age_mem[s2_index_reg] <= new_age;
    end

    assign bus.req_ready        = ready_reg;
    assign bus.init_done        = init_done_reg;
    assign bus.resp_valid       = s2_valid_reg;
    assign bus.resp_way         = s2_valid_reg ? sel_way : '0;
    assign bus.resp_was_invalid = s2_valid_reg && was_invalid;

endmodule

// File: tb/tb_lru_replacer.sv
// Self-checking bench for lru_replacer (4 ways, 128 sets): vector table plus reset corner cases.
module tb_lru_replacer;
    import lru_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    lru_replacer_if #(.NUM_WAYS(4), .NUM_SETS(128)) bus ();

    lru_replacer #(.NUM_WAYS(4), .NUM_SETS(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [1:0] op;
        int         idx;
        int         way;
        logic [3:0] mask;
        int         exp_way;
        logic       exp_inv;
    } vec_t;

    typedef struct {
        int   way;
        logic inv;
        int   cyc;
        int   tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    // Scoreboard: every response must match the oldest outstanding expectation, one cycle after issue.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            tests = tests + 1;
            if (sb.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_resp way=%0d inv=%0d cyc=%0d required no response",
                         bus.resp_way, bus.resp_was_invalid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (int'(bus.resp_way) != e.way || bus.resp_was_invalid != e.inv || cyc != e.cyc) begin
                    fails = fails + 1;
                    $display("FAIL resp[%0d] way=%0d inv=%0d cyc=%0d required way=%0d inv=%0d cyc=%0d",
                             e.tag, bus.resp_way, bus.resp_was_invalid, cyc, e.way, e.inv, e.cyc);
                end else begin
                    $display("[TB] resp[%0d] way=%0d inv=%0d cyc=%0d ok", e.tag, bus.resp_way,
                             bus.resp_was_invalid, cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int required);
        tests = tests + 1;
        if (actual != required) begin
            fails = fails + 1;
            $display("FAIL %s got=%0d required=%0d", name, actual, required);
        end else begin
            $display("[TB] %s = %0d ok", name, actual);
        end
    endtask

    // Called just after a posedge; request is accepted on the next posedge.
    task automatic issue(input logic [1:0] op, input int idx, input int way, input logic [3:0] mask,
                         input int exp_way, input logic exp_inv, input int tag);
        exp_t e;
        bus.req_valid      = 1'b1;
        bus.req_op         = op;
        bus.req_index      = 7'(idx);
        bus.req_way        = 2'(way);
        bus.req_valid_ways = mask;
        e.way = exp_way;
        e.inv = exp_inv;
        e.cyc = cyc + 1;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.req_valid      = 1'b0;
        bus.req_op         = LRU_PEEK;
        bus.req_index      = '0;
        bus.req_way        = '0;
        bus.req_valid_ways = '0;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check(name, sb.size(), 0);
    endtask

    // Release reset at a negedge and count posedges until init_done rises.
    task automatic sweep_check(input string name);
        int cnt;
        int ready_early;
        cnt         = 0;
        ready_early = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (cnt < 1000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.init_done) break;
            if (bus.req_ready) ready_early++;
        end
        check({name, "_cycles"}, cnt, 128);
        check({name, "_ready_during_sweep"}, ready_early, 0);
        check({name, "_ready_after"}, int'(bus.req_ready), 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        go_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", int'(bus.req_ready), 0);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_resp_way", int'(bus.resp_way), 0);
        check("rst_resp_was_invalid", int'(bus.resp_was_invalid), 0);
        check("rst_init_done", int'(bus.init_done), 0);
        sweep_check("sweep1");

        //          op         idx way mask     exp inv
        vecs.push_back('{LRU_PEEK,    0, 0, 4'b1111, 0, 1'b0});
        vecs.push_back('{LRU_PEEK,   77, 3, 4'b0000, 0, 1'b0});
        vecs.push_back('{LRU_ALLOC,   5, 3, 4'b1111, 0, 1'b0}); // set5 -> 3,0,1,2
        vecs.push_back('{LRU_ALLOC,   5, 0, 4'b1111, 1, 1'b0}); // set5 -> 2,3,0,1
        vecs.push_back('{LRU_PEEK,    5, 0, 4'b1111, 2, 1'b0});
        vecs.push_back('{LRU_TOUCH,  10, 2, 4'b1111, 2, 1'b0}); // set10 -> 0,1,3,2
        vecs.push_back('{LRU_PEEK,   10, 1, 4'b1111, 0, 1'b0});
        vecs.push_back('{LRU_ALLOC,  10, 2, 4'b1111, 0, 1'b0}); // set10 -> 3,0,2,1
        vecs.push_back('{LRU_PEEK,   10, 0, 4'b1111, 1, 1'b0});
        vecs.push_back('{LRU_INVAL,  20, 3, 4'b1111, 3, 1'b0}); // set20 -> 1,2,3,0
        vecs.push_back('{LRU_PEEK,   20, 0, 4'b1111, 3, 1'b0});
        vecs.push_back('{LRU_ALLOC,  20, 0, 4'b1111, 3, 1'b0});
        vecs.push_back('{LRU_ALLOC,  30, 0, 4'b1011, 2, 1'b1}); // set30 -> 0,1,3,2
        vecs.push_back('{LRU_PEEK,   30, 2, 4'b1111, 0, 1'b0});
        vecs.push_back('{LRU_ALLOC,  40, 3, 4'b0000, 0, 1'b1});
        vecs.push_back('{LRU_ALLOC, 127, 0, 4'b0111, 3, 1'b1}); // ages stay 0,1,2,3
        vecs.push_back('{LRU_PEEK,  127, 3, 4'b1111, 0, 1'b0});
        vecs.push_back('{LRU_INVAL,   5, 1, 4'b1111, 1, 1'b0}); // set5 -> 3,0,1,2
        vecs.push_back('{LRU_PEEK,    5, 0, 4'b1111, 1, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].idx, vecs[i].way, vecs[i].mask,
                  vecs[i].exp_way, vecs[i].exp_inv, i);
        end
        go_idle();
        drain("table_drain");

        // Reset while a request sits in stage 2: the response must vanish at once.
        bus.req_valid      = 1'b1;
        bus.req_op         = LRU_ALLOC;
        bus.req_index      = 7'd5;
        bus.req_valid_ways = 4'b1111;
        @(posedge clk);
        #2;
        go_idle();
        check("midrst_resp_before", int'(bus.resp_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", int'(bus.resp_valid), 0);
        check("midrst_resp_way", int'(bus.resp_way), 0);
        check("midrst_req_ready", int'(bus.req_ready), 0);
        repeat (3) @(negedge clk);
        sweep_check("sweep2");

        // Set 5 must be back to ages 0,1,2,3: successive ALLOCs walk ways in order.
        issue(LRU_PEEK,  5, 2, 4'b1111, 0, 1'b0, 100);
        issue(LRU_ALLOC, 5, 0, 4'b1111, 0, 1'b0, 101);
        issue(LRU_ALLOC, 5, 0, 4'b1111, 1, 1'b0, 102);
        issue(LRU_ALLOC, 5, 0, 4'b1111, 2, 1'b0, 103);
        issue(LRU_ALLOC, 5, 0, 4'b1111, 3, 1'b0, 104);
        go_idle();
        drain("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
